// File: rtl/nic_injector_if.sv
// -----------------------------------------------------------------------------
// nic_injector_if
// Bundles the core-side handshake, the router-side flit/credit link and the
// status outputs of the injection NIC.
//   slave  : view used by nic_injector (takes core flits and credits,
//            drives the router flit and status)
//   master : view used by whoever drives the core side and returns credits
// Signals:
//   core_valid/core_ready/core_dest/core_payload : core flit handshake
//   credit_in                                    : credit-return pulse
//   out_data/out_valid                           : flit to router local port
//   credit_count/fifo_count/sent_count/credit_err: status
// -----------------------------------------------------------------------------
interface nic_injector_if #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int NUM_VC          = 4,
    parameter int NUM_ROUTERS     = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int ROUTER_ID_BITS  = $clog2(NUM_ROUTERS)
);
    localparam int PAYLOAD_BITS = FLIT_DATA_WIDTH - ROUTER_ID_BITS;
    localparam int CREDIT_BITS  = $clog2(NUM_VC + 1);
    localparam int COUNT_BITS   = $clog2(FIFO_DEPTH + 1);

    logic                       core_valid;
    logic                       core_ready;
    logic [ROUTER_ID_BITS-1:0]  core_dest;
    logic [PAYLOAD_BITS-1:0]    core_payload;
    logic                       credit_in;
    logic [FLIT_DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic [CREDIT_BITS-1:0]     credit_count;
    logic [COUNT_BITS-1:0]      fifo_count;
    logic [15:0]                sent_count;
    logic                       credit_err;

    modport slave (
        input  core_valid, core_dest, core_payload, credit_in,
        output core_ready, out_data, out_valid,
               credit_count, fifo_count, sent_count, credit_err
    );

    modport master (
        output core_valid, core_dest, core_payload, credit_in,
        input  core_ready, out_data, out_valid,
               credit_count, fifo_count, sent_count, credit_err
    );
endinterface

// File: rtl/nic_injector.sv
// -----------------------------------------------------------------------------
// nic_injector
// Injection-side network interface for one mesh node. Flits from the local
// core are buffered in a circular FIFO, stamped with their destination router
// ID in the top bits, and sent to the router's local input port under
// credit-based flow control (one credit per router VC).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : nic_injector_if.slave (core handshake, router link, status)
// -----------------------------------------------------------------------------
module nic_injector #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int NUM_VC          = 4,
    parameter int NUM_ROUTERS     = 16,
    parameter int ROUTER_ID       = 0,
    parameter int ROUTER_ID_BITS  = $clog2(NUM_ROUTERS),
    parameter int FIFO_DEPTH      = 8
) (
    input  logic           clk,
    input  logic           reset,
    nic_injector_if.slave  bus
);
    localparam int PTR_BITS    = $clog2(FIFO_DEPTH);
    localparam int CREDIT_BITS = $clog2(NUM_VC + 1);
    localparam int COUNT_BITS  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_CREDIT
    } state_t;

    // FIFO storage: no reset so it maps onto RAM; only pointers/count reset.
    logic [FLIT_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]        r_wr_ptr;
    logic [PTR_BITS-1:0]        r_rd_ptr;
    logic [COUNT_BITS-1:0]      r_fifo_count;
    logic [CREDIT_BITS-1:0]     r_credit_count;
    logic [15:0]                r_sent_count;
    logic                       r_credit_err;
    logic [FLIT_DATA_WIDTH-1:0] r_out_data;
    state_t                     r_state;

    logic                       w_core_ready;
    logic                       w_push;
    logic                       w_send;
    logic                       w_credit_overflow;
    logic [FLIT_DATA_WIDTH-1:0] w_flit;

    // Ready depends only on reset and the registered occupancy, never on
    // core_valid, so the core can't form a combinational loop through us.
    assign w_core_ready = !reset && (r_fifo_count < COUNT_BITS'(FIFO_DEPTH));
    assign w_push       = bus.core_valid && w_core_ready;

    // Send decision uses the pre-edge credit count: a credit arriving at this
    // edge only becomes usable on the next one.
    assign w_send = (r_fifo_count != '0) && (r_credit_count != '0);

    // A returned credit with the counter already full and nothing being spent
    // is a router protocol violation.
    assign w_credit_overflow = bus.credit_in && !w_send &&
                               (r_credit_count == CREDIT_BITS'(NUM_VC));

    // Destination goes in the top bits where the router's route compute
    // looks for it.
    assign w_flit = {bus.core_dest, bus.core_payload};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_count   <= '0;
            r_credit_count <= CREDIT_BITS'(NUM_VC);
            r_sent_count   <= '0;
            r_credit_err   <= 1'b0;
            r_out_data     <= '0;
            r_state        <= S_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
            end
            r_fifo_count <= r_fifo_count + COUNT_BITS'(w_push) - COUNT_BITS'(w_send);

            if (w_credit_overflow) begin
                r_credit_err <= 1'b1;          // count saturates: left unchanged
            end else begin
                r_credit_count <= r_credit_count - CREDIT_BITS'(w_send)
                                                 + CREDIT_BITS'(bus.credit_in);
            end

            // State reflects the action taken at this edge; out_valid is
            // decoded from it so the output is purely registered.
            if (r_fifo_count == '0) begin
                r_state <= S_IDLE;
            end else if (w_send) begin
                r_state      <= S_SEND;
                r_out_data   <= r_mem[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_sent_count <= r_sent_count + 16'd1;
            end else begin
                r_state <= S_WAIT_CREDIT;      // out_data holds its last flit
            end
        end
    end

    assign bus.core_ready   = w_core_ready;
    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = (r_state == S_SEND);
    assign bus.credit_count = r_credit_count;
    assign bus.fifo_count   = r_fifo_count;
    assign bus.sent_count   = r_sent_count;
    assign bus.credit_err   = r_credit_err;
endmodule

// File: tb/tb_nic_injector.sv
// -----------------------------------------------------------------------------
// tb_nic_injector
// Drives nic_injector through directed phases with randomized flit contents
// and random traffic/credit returns. A queue-based reference model predicts
// FIFO contents, credits and the sent flit stream; a negedge monitor pops the
// expected flit whenever the DUT asserts out_valid and checks all status.
// -----------------------------------------------------------------------------
module tb_nic_injector;
    localparam int W     = 32;
    localparam int NVC   = 4;
    localparam int NR    = 16;
    localparam int DEPTH = 8;
    localparam int RB    = $clog2(NR);
    localparam int PB    = W - RB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nic_injector_if #(
        .FLIT_DATA_WIDTH(W), .NUM_VC(NVC), .NUM_ROUTERS(NR), .FIFO_DEPTH(DEPTH)
    ) bus ();

    nic_injector #(
        .FLIT_DATA_WIDTH(W), .NUM_VC(NVC), .NUM_ROUTERS(NR),
        .ROUTER_ID(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [W-1:0] m_q[$];      // flits held in the injection buffer
    logic [W-1:0] exp_q[$];    // flits the DUT must emit, in order
    int           m_credits = NVC;
    int           m_sent    = 0;
    bit           m_err     = 1'b0;
    bit           m_valid   = 1'b0;
    logic [W-1:0] m_data    = '0;

    always @(posedge clk) begin
        bit send;
        bit push;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_credits = NVC;
            m_sent    = 0;
            m_err     = 1'b0;
            m_valid   = 1'b0;
            m_data    = '0;
        end else begin
            send = (m_q.size() > 0) && (m_credits > 0);
            push = bus.core_valid && (m_q.size() < DEPTH);
            if (send) begin
                m_data = m_q.pop_front();
                exp_q.push_back(m_data);
                m_sent = (m_sent + 1) % 65536;
                m_credits = m_credits - 1;
            end
            m_valid = send;
            if (push) m_q.push_back({bus.core_dest, bus.core_payload});
            if (bus.credit_in) begin
                if (m_credits == NVC) m_err = 1'b1;
                else m_credits = m_credits + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        check("core_ready", 64'(bus.core_ready), 64'(!reset && (m_q.size() < DEPTH)));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_data: got %0h expected no flit at %0t", bus.out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e));
            end
        end else begin
            check("out_data_hold", 64'(bus.out_data), 64'(m_data));
        end
        check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
        check("credit_count", 64'(bus.credit_count), 64'(m_credits));
        check("sent_count", 64'(bus.sent_count), 64'(m_sent));
        check("credit_err", 64'(bus.credit_err), 64'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [RB-1:0] d, input logic [PB-1:0] p, input bit c);
        bus.core_valid   = v;
        bus.core_dest    = d;
        bus.core_payload = p;
        bus.credit_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic push_rand(input bit c);
        step(1'b1, RB'($urandom_range(0, NR - 1)), PB'($urandom), c);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
    endtask

    // Credit pulse that never overflows: returned only while below NUM_VC.
    function automatic bit safe_credit(input int pct);
        return (m_credits < NVC) && ($urandom_range(0, 99) < pct);
    endfunction

    initial begin
        bus.core_valid   = 1'b0;
        bus.core_dest    = '0;
        bus.core_payload = '0;
        bus.credit_in    = 1'b0;

        // Reset then a single flit.
        do_reset(2);
        step(1'b1, RB'(5), PB'('h1A3), 1'b0);
        idle(4);
        step(1'b0, '0, '0, 1'b1);          // return the spent credit
        idle(2);

        // Credit exhaustion: 6 pushes, 4 go out, 2 wait; one credit frees one.
        for (int i = 0; i < 6; i++) push_rand(1'b0);
        idle(4);
        step(1'b0, '0, '0, 1'b1);
        idle(4);

        // FIFO full with no credits: 9 offers, only 7 fit behind the leftover.
        for (int i = 0; i < 9; i++) push_rand(1'b0);
        idle(2);

        // Drain with credits restored, then random traffic across pointer wrap.
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, safe_credit(100));
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), RB'($urandom_range(0, NR - 1)),
                 PB'($urandom), safe_credit(60));

        // Steady state: push every cycle with prompt credit return.
        for (int i = 0; i < 40; i++) push_rand(safe_credit(100));

        // Overflow: drain, top credits up to NUM_VC, then one extra pulse.
        for (int i = 0; i < 60 && (bus.fifo_count != 0 || m_credits < NVC); i++)
            step(1'b0, '0, '0, safe_credit(100));
        check("drain_bound", 64'(bus.fifo_count), 64'(0));
        step(1'b0, '0, '0, 1'b1);
        idle(4);
        push_rand(1'b0);                   // error stays set through traffic
        idle(3);

        // Reset mid-stream: 3 queued, 1 credit just arrived, then reset.
        do_reset(2);
        for (int i = 0; i < 6; i++) push_rand(1'b0);
        idle(4);
        push_rand(1'b0);
        step(1'b0, '0, '0, 1'b1);
        do_reset(2);
        idle(4);

        // Short random tail after reset.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), RB'($urandom_range(0, NR - 1)),
                 PB'($urandom), safe_credit(50));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
